scan_scheduler: RTL and testbench

// Slave-side scheduler for the shared scan receiver. Counts CLKN slot ticks and opens page-scan
// and inquiry-scan windows at their programmed intervals. Arbitrates between the two when their

---
 rtl/bt_pkg.sv | 26 ++
 rtl/scan_scheduler_if.sv | 40 ++++
 rtl/scan_interval_cnt.sv | 45 ++++
 rtl/scan_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_scan_scheduler.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bt_pkg.sv
// Shared definitions for the slave-side scan scheduler: FSM encoding,
// scan kind tags, counter widths and the default scan timing values.
package bt_pkg;

    localparam int SCH_CNT_W   = 13;
    localparam int SCH_RSPTO_W = 4;

    // Default page scan timing, in slots (2048 = 0x800).
    localparam logic [SCH_CNT_W-1:0]   TPSCAN_DEF  = 13'd2048;
    localparam logic [SCH_CNT_W-1:0]   TWPSCAN_DEF = 13'd18;
    localparam logic [SCH_RSPTO_W-1:0] RESP_TO_DEF = 4'd8;

    typedef enum logic [1:0] {
        SCH_IDLE  = 2'd0,
        SCH_PSCAN = 2'd1,
        SCH_ISCAN = 2'd2,
        SCH_RESP  = 2'd3
    } sch_state_t;

    // Which kind of scan owns the receiver (also the last_srv encoding).
    typedef enum logic {
        KIND_PAGE = 1'b0,
        KIND_INQ  = 1'b1
    } scan_kind_t;

endpackage

// File: rtl/scan_scheduler_if.sv
// Bundle between the slot clock / register block / correlator and the scan
// scheduler. The slave modport is the scheduler's view; master is the
// surrounding logic that feeds it.
interface scan_sched_if #(
    parameter int CNT_W   = 13,
    parameter int RSPTO_W = 4
);
    logic               s_tslot_p;
    logic [27:0]        CLKN_slave;
    logic               regi_pscan_en;
    logic               regi_iscan_en;
    logic [CNT_W-1:0]   regi_Tpscan;
    logic [CNT_W-1:0]   regi_Twpscan;
    logic [CNT_W-1:0]   regi_Tiscan;
    logic [CNT_W-1:0]   regi_Twiscan;
    logic [RSPTO_W-1:0] regi_resp_to;
    logic               conn_busy;
    logic               corre_sync_p;
    logic               resp_done_p;
    logic               pagescan;
    logic               inquiryscan;
    logic               scan_resp;
    logic               scan_start_p;
    logic               scan_end_p;

    modport slave (
        input  s_tslot_p, CLKN_slave, regi_pscan_en, regi_iscan_en,
               regi_Tpscan, regi_Twpscan, regi_Tiscan, regi_Twiscan,
               regi_resp_to, conn_busy, corre_sync_p, resp_done_p,
        output pagescan, inquiryscan, scan_resp, scan_start_p, scan_end_p
    );

    modport master (
        output s_tslot_p, CLKN_slave, regi_pscan_en, regi_iscan_en,
               regi_Tpscan, regi_Twpscan, regi_Tiscan, regi_Twiscan,
               regi_resp_to, conn_busy, corre_sync_p, resp_done_p,
        input  pagescan, inquiryscan, scan_resp, scan_start_p, scan_end_p
    );

endinterface

// File: rtl/scan_interval_cnt.sv
// Scan interval counter: counts slot ticks while enabled and flags a due
// pulse every T ticks (the tick on which the count sits at T-1, which then
// wraps to 0). T=0 behaves as T=1. Cleared while disabled.
module scan_interval_cnt #(
    parameter int CNT_W = 13
) (
    input  logic             clk_6M,
    input  logic             rstz,
    input  logic             en_i,
    input  logic [CNT_W-1:0] t_i,
    input  logic             tick_i,
    output logic             due_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] t_last;

    // T=0 and T=1 both give a last count of 0, i.e. due on every tick.
    assign t_last = (t_i == '0) ? '0 : t_i - CNT_W'(1);

    // Next count and due pulse; >= keeps the wrap safe if T shrinks mid-count.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        cnt_d = cnt_q;
        due_o = 1'b0;
        if (!en_i) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q >= t_last) begin
                cnt_d = '0;
                due_o = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk_6M) begin
        // NOTE: state uses non-blocking assignments; reset is sampled on the clock edge only.
        if (!rstz) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/scan_scheduler.sv
// Scan scheduler: opens page/inquiry scan windows on even slot pairs when
// their interval counters come due, arbitrates collisions round-robin,
// and holds the receiver during a correlation response.
module scan_scheduler
    import bt_pkg::*;
#(
    parameter int CNT_W   = SCH_CNT_W,
    parameter int RSPTO_W = SCH_RSPTO_W
) (
    input  logic       clk_6M,
    input  logic       rstz,
    scan_sched_if.slave bus
);

    // Windows may only open on a slot boundary with CLKN[1] set.
    logic sq;
    assign sq = bus.s_tslot_p & bus.CLKN_slave[1];

    // Only CLKN[1] matters; the rest of the native clock is intentionally ignored.
    logic unused_clkn;
    assign unused_clkn = ^{bus.CLKN_slave[27:2], bus.CLKN_slave[0]};

    // Zero-valued intervals, windows and timeout all behave as 1.
    logic [CNT_W-1:0]   tp_eff, ti_eff, twp_eff, twi_eff;
    logic [RSPTO_W-1:0] resp_eff;
    assign tp_eff   = (bus.regi_Tpscan  == '0) ? CNT_W'(1) : bus.regi_Tpscan;
    assign ti_eff   = (bus.regi_Tiscan  == '0) ? CNT_W'(1) : bus.regi_Tiscan;
    assign twp_eff  = (bus.regi_Twpscan == '0) ? CNT_W'(1) : bus.regi_Twpscan;
    assign twi_eff  = (bus.regi_Twiscan == '0) ? CNT_W'(1) : bus.regi_Twiscan;
    assign resp_eff = (bus.regi_resp_to == '0) ? RSPTO_W'(1) : bus.regi_resp_to;

    // A window at least as long as its interval never closes.
    logic p_cont, i_cont;
    assign p_cont = (twp_eff >= tp_eff);
    assign i_cont = (twi_eff >= ti_eff);

    logic due_p, due_i;

    scan_interval_cnt #(.CNT_W(CNT_W)) u_page_cnt (
        .clk_6M (clk_6M),
        .rstz   (rstz),
        .en_i   (bus.regi_pscan_en),
        .t_i    (bus.regi_Tpscan),
        .tick_i (bus.s_tslot_p),
        .due_o  (due_p)
    );

    scan_interval_cnt #(.CNT_W(CNT_W)) u_inq_cnt (
        .clk_6M (clk_6M),
        .rstz   (rstz),
        .en_i   (bus.regi_iscan_en),
        .t_i    (bus.regi_Tiscan),
        .tick_i (bus.s_tslot_p),
        .due_o  (due_i)
    );

    sch_state_t         state_q, state_d;
    scan_kind_t         kind_q, kind_d;
    scan_kind_t         last_srv_q, last_srv_d;
    logic [CNT_W-1:0]   wcnt_q, wcnt_d;
    logic [RSPTO_W-1:0] tocnt_q, tocnt_d;
    logic               pend_p_q, pend_p_d, pend_i_q, pend_i_d;
    logic               pagescan_q, inquiryscan_q, scan_resp_q;
    logic               scan_start_q, scan_end_q;
    logic               start_d, end_d, serve_p, serve_i;

    // Is each kind's window currently open (including a response hold)?
    logic p_open, i_open, p_ign, i_ign, pe_p, pe_i;
    assign p_open = (state_q == SCH_PSCAN) || (state_q == SCH_RESP && kind_q == KIND_PAGE);
    assign i_open = (state_q == SCH_ISCAN) || (state_q == SCH_RESP && kind_q == KIND_INQ);
    // A continuous window swallows its own due points.
    assign p_ign  = p_cont & p_open;
    assign i_ign  = i_cont & i_open;
    // Pending as seen by the FSM this cycle: stored flag or a due arriving now.
    assign pe_p   = pend_p_q | (due_p & ~p_ign);
    assign pe_i   = pend_i_q | (due_i & ~i_ign);

    // Pending flags: disable clears, serving clears, a due point sets.
    always_comb begin
        pend_p_d = pend_p_q;
        pend_i_d = pend_i_q;
        if (!bus.regi_pscan_en)   pend_p_d = 1'b0;
        else if (serve_p)         pend_p_d = 1'b0;
        else if (due_p && !p_ign) pend_p_d = 1'b1;
        if (!bus.regi_iscan_en)   pend_i_d = 1'b0;
        else if (serve_i)         pend_i_d = 1'b0;
        else if (due_i && !i_ign) pend_i_d = 1'b1;
    end

    // Scheduler FSM: window start/arbitration, window countdown, response hold.
    always_comb begin
        logic en_cur, cont_cur, pick_i;
        state_d    = state_q;
        kind_d     = kind_q;
        last_srv_d = last_srv_q;
        wcnt_d     = wcnt_q;
        tocnt_d    = tocnt_q;
        start_d    = 1'b0;
        end_d      = 1'b0;
        serve_p    = 1'b0;
        serve_i    = 1'b0;
        pick_i     = 1'b0;
        en_cur     = (kind_q == KIND_INQ) ? bus.regi_iscan_en : bus.regi_pscan_en;
        cont_cur   = (kind_q == KIND_INQ) ? i_cont : p_cont;

        case (state_q)
            SCH_IDLE: begin
                if (sq && !bus.conn_busy && (pe_p || pe_i)) begin
                    start_d = 1'b1;
                    if (pe_p && pe_i) begin
                        // Collision: serve the kind that was not served last time.
                        pick_i     = (last_srv_q == KIND_PAGE);
                        last_srv_d = pick_i ? KIND_INQ : KIND_PAGE;
                    end else begin
                        pick_i = pe_i;
                    end
                    if (pick_i) begin
                        state_d = SCH_ISCAN;
                        kind_d  = KIND_INQ;
                        wcnt_d  = twi_eff - CNT_W'(1);
                        serve_i = 1'b1;
                    end else begin
                        state_d = SCH_PSCAN;
                        kind_d  = KIND_PAGE;
                        wcnt_d  = twp_eff - CNT_W'(1);
                        serve_p = 1'b1;
                    end
                end
            end
            SCH_PSCAN, SCH_ISCAN: begin
                if (!en_cur) begin
                    end_d   = 1'b1;
                    state_d = SCH_IDLE;
                end else if (bus.corre_sync_p) begin
                    // Correlation beats a simultaneous window close.
                    state_d = SCH_RESP;
                    tocnt_d = resp_eff;
                end else if (bus.s_tslot_p && !cont_cur) begin
                    if (wcnt_q == '0) begin
                        end_d   = 1'b1;
                        state_d = SCH_IDLE;
                    end else begin
                        wcnt_d = wcnt_q - CNT_W'(1);
                    end
                end
            end
            SCH_RESP: begin
                if (bus.resp_done_p || (bus.s_tslot_p && tocnt_q <= RSPTO_W'(1))) begin
                    end_d   = 1'b1;
                    state_d = SCH_IDLE;
                end else if (bus.s_tslot_p) begin
                    tocnt_d = tocnt_q - RSPTO_W'(1);
                end
            end
            default: state_d = SCH_IDLE;
        endcase
    end

    // State, counters and registered outputs (decoded from next state).
    always_ff @(posedge clk_6M) begin
        if (!rstz) begin
            state_q       <= SCH_IDLE;
            kind_q        <= KIND_PAGE;
            last_srv_q    <= KIND_PAGE;
            wcnt_q        <= '0;
            tocnt_q       <= '0;
            pend_p_q      <= 1'b0;
            pend_i_q      <= 1'b0;
            pagescan_q    <= 1'b0;
            inquiryscan_q <= 1'b0;
            scan_resp_q   <= 1'b0;
            scan_start_q  <= 1'b0;
            scan_end_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            kind_q        <= kind_d;
            last_srv_q    <= last_srv_d;
            wcnt_q        <= wcnt_d;
            tocnt_q       <= tocnt_d;
            pend_p_q      <= pend_p_d;
            pend_i_q      <= pend_i_d;
            pagescan_q    <= (state_d == SCH_PSCAN) ||
                             (state_d == SCH_RESP && kind_d == KIND_PAGE);
            inquiryscan_q <= (state_d == SCH_ISCAN) ||
                             (state_d == SCH_RESP && kind_d == KIND_INQ);
            scan_resp_q   <= (state_d == SCH_RESP);
            scan_start_q  <= start_d;
            scan_end_q    <= end_d;
        end
    end

    assign bus.pagescan     = pagescan_q;
    assign bus.inquiryscan  = inquiryscan_q;
    assign bus.scan_resp    = scan_resp_q;
    assign bus.scan_start_p = scan_start_q;
    assign bus.scan_end_p   = scan_end_q;

endmodule

// File: tb/tb_scan_scheduler.sv
// Directed bench for scan_scheduler. One slot = 4 clocks here; slot k drives
// CLKN_slave = k<<1, so CLKN[1] is set on odd slots (the start qualifier).
// With an interval counter enabled from slot 0, its due point lands on slot
// T-1, 2T-1, ... and a window of Tw slots is open after slots s..s+Tw-1.
module tb_scan_scheduler;

    logic clk_6M = 1'b0;
    logic rstz   = 1'b0;
    int   errors = 0;
    int   checks = 0;

    // Snapshot of the outputs taken one clock after each stimulus edge.
    logic s_ps, s_is, s_rs, s_st, s_en;

    always #5 clk_6M = ~clk_6M;

    scan_sched_if #(.CNT_W(13), .RSPTO_W(4)) bus ();

    scan_scheduler dut (
        .clk_6M (clk_6M),
        .rstz   (rstz),
        .bus    (bus.slave)
    );

    task automatic snap();
        s_ps = bus.pagescan;
        s_is = bus.inquiryscan;
        s_rs = bus.scan_resp;
        s_st = bus.scan_start_p;
        s_en = bus.scan_end_p;
    endtask

    // One slot tick for slot kk (optionally with a coincident correlation hit).
    task automatic do_slot(input int kk, input logic corre);
        @(negedge clk_6M);
        bus.s_tslot_p    = 1'b1;
        bus.CLKN_slave   = 28'(kk) << 1;
        bus.corre_sync_p = corre;
        @(negedge clk_6M);
        bus.s_tslot_p    = 1'b0;
        bus.corre_sync_p = 1'b0;
        snap();
        repeat (2) @(negedge clk_6M);
    endtask

    task automatic pulse_corre();
        @(negedge clk_6M);
        bus.corre_sync_p = 1'b1;
        @(negedge clk_6M);
        bus.corre_sync_p = 1'b0;
        snap();
    endtask

    task automatic configure(input int tp, input int twp, input int ti, input int twi,
                             input logic pen, input logic ien, input int rto, input logic busy);
        bus.s_tslot_p     = 1'b0;
        bus.CLKN_slave    = '0;
        bus.regi_pscan_en = 1'b0;
        bus.regi_iscan_en = 1'b0;
        bus.regi_Tpscan   = 13'(tp);
        bus.regi_Twpscan  = 13'(twp);
        bus.regi_Tiscan   = 13'(ti);
        bus.regi_Twiscan  = 13'(twi);
        bus.regi_resp_to  = 4'(rto);
        bus.conn_busy     = busy;
        bus.corre_sync_p  = 1'b0;
        bus.resp_done_p   = 1'b0;
        @(negedge clk_6M);
        rstz = 1'b0;
        repeat (2) @(negedge clk_6M);
        rstz = 1'b1;
        bus.regi_pscan_en = pen;
        bus.regi_iscan_en = ien;
    endtask

    task automatic test_reset();
        configure(16, 4, 16, 4, 1'b1, 1'b1, 3, 1'b0);
        rstz = 1'b0;
        @(negedge clk_6M);
        snap();
        rstz = 1'b1;
        checks++;
        if ({s_ps, s_is, s_rs, s_st, s_en} !== 5'b0) begin
            errors++;
            $display("FAIL reset outputs got %b exp 00000", {s_ps, s_is, s_rs, s_st, s_en});
        end
    endtask

    task automatic test_page_only();
        logic e_ps, e_st, e_en;
        configure(16, 4, 16, 4, 1'b1, 1'b0, 3, 1'b0);
        for (int kk = 0; kk < 40; kk++) begin
            do_slot(kk, 1'b0);
            e_ps = (kk >= 15) && (((kk - 15) % 16) < 4);
            e_st = (kk >= 15) && (((kk - 15) % 16) == 0);
            e_en = (kk >= 19) && (((kk - 19) % 16) == 0);
            checks += 3;
            if (s_ps !== e_ps) begin
                errors++;
                $display("FAIL page_only pagescan slot %0d got %b exp %b", kk, s_ps, e_ps);
            end
            if (s_st !== e_st) begin
                errors++;
                $display("FAIL page_only start slot %0d got %b exp %b", kk, s_st, e_st);
            end
            if (s_en !== e_en) begin
                errors++;
                $display("FAIL page_only end slot %0d got %b exp %b", kk, s_en, e_en);
            end
        end
    endtask

    // Both due together on slots 7, 15, 23, ...; winners alternate, losers follow.
    task automatic test_alternate();
        logic [63:0] m_p, m_i;
        m_p = 64'h0000_0001_9801_9800;  // page open after slots 11,12,15,16,27,28,31,32
        m_i = 64'h0000_0198_0198_0180;  // inquiry open after 7,8,19,20,23,24,35,36,39,40
        configure(8, 2, 8, 2, 1'b1, 1'b1, 3, 1'b0);
        for (int kk = 0; kk <= 40; kk++) begin
            do_slot(kk, 1'b0);
            checks += 2;
            if (s_ps !== m_p[kk]) begin
                errors++;
                $display("FAIL alternate pagescan slot %0d got %b exp %b", kk, s_ps, m_p[kk]);
            end
            if (s_is !== m_i[kk]) begin
                errors++;
                $display("FAIL alternate inquiryscan slot %0d got %b exp %b", kk, s_is, m_i[kk]);
            end
        end
    endtask

    task automatic test_continuous();
        configure(16, 20, 16, 4, 1'b1, 1'b0, 3, 1'b0);
        for (int kk = 0; kk < 50; kk++) begin
            do_slot(kk, 1'b0);
            checks += 3;
            if (s_ps !== (kk >= 15)) begin
                errors++;
                $display("FAIL continuous pagescan slot %0d got %b exp %b", kk, s_ps, kk >= 15);
            end
            if (s_st !== (kk == 15)) begin
                errors++;
                $display("FAIL continuous start slot %0d got %b exp %b", kk, s_st, kk == 15);
            end
            if (s_en !== 1'b0) begin
                errors++;
                $display("FAIL continuous end slot %0d got %b exp 0", kk, s_en);
            end
        end
    endtask

    // Correlation after slot 16 (2nd slot of the window), timeout 3 slots.
    task automatic test_resp_timeout();
        configure(16, 4, 16, 4, 1'b1, 1'b0, 3, 1'b0);
        for (int kk = 0; kk <= 16; kk++) do_slot(kk, 1'b0);
        pulse_corre();
        checks += 2;
        if ({s_ps, s_rs} !== 2'b11) begin
            errors++;
            $display("FAIL resp_enter {pagescan,scan_resp} got %b exp 11", {s_ps, s_rs});
        end
        if (s_en !== 1'b0) begin
            errors++;
            $display("FAIL resp_enter end got %b exp 0", s_en);
        end
        for (int kk = 17; kk <= 18; kk++) begin
            do_slot(kk, 1'b0);
            checks++;
            if ({s_ps, s_rs, s_en} !== 3'b110) begin
                errors++;
                $display("FAIL resp_hold slot %0d {ps,rs,end} got %b exp 110", kk, {s_ps, s_rs, s_en});
            end
        end
        do_slot(19, 1'b0);
        checks++;
        if ({s_ps, s_rs, s_en} !== 3'b001) begin
            errors++;
            $display("FAIL resp_expire {ps,rs,end} got %b exp 001", {s_ps, s_rs, s_en});
        end
        for (int kk = 20; kk <= 31; kk++) do_slot(kk, 1'b0);
        checks++;
        if ({s_ps, s_st} !== 2'b11) begin
            errors++;
            $display("FAIL resp_reopen {ps,start} got %b exp 11", {s_ps, s_st});
        end
    endtask

    // Tw=1: the tick that would close the window carries a correlation hit.
    task automatic test_corre_vs_close();
        configure(16, 1, 16, 4, 1'b1, 1'b0, 0, 1'b0);
        for (int kk = 0; kk <= 15; kk++) do_slot(kk, 1'b0);
        do_slot(16, 1'b1);
        checks++;
        if ({s_ps, s_rs, s_en} !== 3'b110) begin
            errors++;
            $display("FAIL corre_vs_close {ps,rs,end} got %b exp 110", {s_ps, s_rs, s_en});
        end
        do_slot(17, 1'b0);
        checks++;
        if ({s_ps, s_rs, s_en} !== 3'b001) begin
            errors++;
            $display("FAIL corre_resp_to0 {ps,rs,end} got %b exp 001", {s_ps, s_rs, s_en});
        end
    endtask

    task automatic test_enable_drop();
        configure(16, 4, 16, 4, 1'b1, 1'b0, 3, 1'b0);
        for (int kk = 0; kk <= 16; kk++) do_slot(kk, 1'b0);
        @(negedge clk_6M);
        bus.regi_pscan_en = 1'b0;
        @(negedge clk_6M);
        snap();
        checks++;
        if ({s_ps, s_en} !== 2'b01) begin
            errors++;
            $display("FAIL enable_drop {ps,end} got %b exp 01", {s_ps, s_en});
        end
    endtask

    task automatic test_busy_then_reset();
        configure(16, 4, 16, 4, 1'b1, 1'b0, 3, 1'b1);
        for (int kk = 0; kk <= 16; kk++) begin
            do_slot(kk, 1'b0);
            if (kk >= 15) begin
                checks++;
                if (s_ps !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_hold slot %0d pagescan got %b exp 0", kk, s_ps);
                end
            end
        end
        bus.conn_busy = 1'b0;
        do_slot(17, 1'b0);
        checks++;
        if ({s_ps, s_st} !== 2'b11) begin
            errors++;
            $display("FAIL busy_release {ps,start} got %b exp 11", {s_ps, s_st});
        end
        do_slot(18, 1'b0);
        checks++;
        if (s_ps !== 1'b1) begin
            errors++;
            $display("FAIL busy_window slot 18 pagescan got %b exp 1", s_ps);
        end
        @(negedge clk_6M);
        rstz = 1'b0;
        @(negedge clk_6M);
        snap();
        rstz = 1'b1;
        checks++;
        if ({s_ps, s_is, s_rs, s_st, s_en} !== 5'b0) begin
            errors++;
            $display("FAIL midwindow_reset outputs got %b exp 00000", {s_ps, s_is, s_rs, s_st, s_en});
        end
    endtask

    initial begin
        test_reset();
        test_page_only();
        test_alternate();
        test_continuous();
        test_resp_timeout();
        test_corre_vs_close();
        test_enable_drop();
        test_busy_then_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
